race_game_controller: RTL and testbench
=======================================

// Module: race_game_controller
// PURPOSE
//  Top-level game sequencer for the LED racer. Drives the shared current_screen bus and player clear strobe to all
//  per-player button blocks. Watches their ready flags and positions, decides start, winner and return to lobby.
//  Sits between the player button instances and the LED strip renderer.
// PARAMETERS
//  N_PLAYERS      4         number of player lanes (2..8)
//  MAX_POS        16        track length; a player finishes when pos == MAX_POS-1
//  FINISH_CYCLES  50000000  cycles the winner screen is held before returning to lobby
//  IDLE_CYCLES    500000000 race abort timeout with no player activity
//  CD_CYCLES      25000000  length of one countdown step (RACE_COUNTDOWN_EN only)
// PORTS
//  clk            in   1              system clock
//  reset          in   1              synchronous, active-high
//  start_btn      in   1              raw start button (level, already synchronised)
//  ready          in   N_PLAYERS      per-player ready_to_play
//  activity       in   N_PLAYERS      per-player button level
//  pos_flat       in   N_PLAYERS*PW   per-player cur_pos, lane i at [i*PW +: PW], PW=$clog2(MAX_POS)
//  current_screen out  2              00 lobby, 01 race, 10 winner, 11 countdown
//  players_reset  out  1              clear request to all player blocks
//  winner_id      out  $clog2(N_PLAYERS) winning lane index
//  winner_valid   out  1              high while winner_id is meaningful
//  countdown      out  2              remaining countdown steps (3..1), 0 otherwise
// BEHAVIOUR
//  States: CLEAR, LOBBY, COUNTDOWN, RACE, WINNER. On reset: state=CLEAR, screen=00, players_reset=1,
//   winner_valid=0, winner_id=0, countdown=0, all timers 0.
//  CLEAR: players_reset=1, screen=00. Held min 2 cycles and until ready==0 and every pos==0.
//   Player blocks only sample clear while idle, so it must be held. Then -> LOBBY, players_reset=0 next cycle.
//  LOBBY: screen=00. start_btn rising edge (registered edge detect, 1-cycle latency) with ready!=0 -> COUNTDOWN
//   (or RACE, see CONFIGURATION). Edge with ready==0 is ignored. Holding start_btn never retriggers.
//  RACE: screen=01. Idle timer counts cycles with activity==0; it clears on any activity bit.
//   Idle timer reaching IDLE_CYCLES-1 -> CLEAR (abort, no winner).
//  Finish detect: any lane with ready[i]=1 and pos==MAX_POS-1. Lanes with ready[i]=0 are ignored.
//   Detect is combinational on the inputs; transition to WINNER on the next edge.
//  Simultaneous finish in the same cycle: lowest lane index wins.
//  Finish and idle timeout in the same cycle: finish wins.
//  WINNER: screen=10, winner_valid=1, winner_id latched on entry and stable throughout. Hold timer runs
//   FINISH_CYCLES cycles, then -> CLEAR with winner_valid=0 and winner_id held at its last value.
//   start_btn is ignored in WINNER.
//  Timers: one shared counter, zeroed on every state change, sized $clog2(max of the cycle parameters)+1.
//   Saturating, never wraps.
//  reset mid-race or mid-winner: immediate return to CLEAR; no winner is reported.
//  Position values above MAX_POS-1 are never expected. They are treated as finished (>= compare).
// CONFIGURATION
//  RACE_COUNTDOWN_EN defined: LOBBY start -> COUNTDOWN, screen=11. countdown output runs 3,2,1,
//   each for CD_CYCLES cycles, then -> RACE with countdown=0.
//   If ready becomes 0 during COUNTDOWN -> LOBBY.
//   In COUNTDOWN, players' presses do not move them (player blocks only advance on screen 01).
//  RACE_COUNTDOWN_EN undefined: LOBBY start goes straight to RACE. COUNTDOWN state and CD_CYCLES logic absent.
//   countdown tied to 0 and screen 11 never driven.
// TESTING (small params: N_PLAYERS=4, MAX_POS=16, FINISH_CYCLES=8, IDLE_CYCLES=20, CD_CYCLES=4)
//  Reset with ready=0001, pos0=5 -> players_reset stays 1 until the bench clears ready/pos.
//   Then LOBBY, screen=00.
//  LOBBY, ready=0000, start edge -> stays 00.
//   ready=0101 plus start edge -> screen 01 (no _EN) or 11 for 12 cycles then 01 (with _EN).
//  RACE, lanes 1 and 3 both reach pos=15 the same cycle -> screen=10, winner_id=1, winner_valid=1.
//   After 8 cycles -> CLEAR.
//  RACE, lane 2 pos=15 but ready[2]=0 -> no winner.
//   No activity for 20 cycles -> CLEAR, winner_valid=0.
//  Assert reset during WINNER -> next cycle screen=00, players_reset=1, winner_valid=0.
//  Hold start_btn high through CLEAR into LOBBY -> no start until it is released and pressed again.

Source files
------------

// File: rtl/race_game_controller.sv
// Top-level LED racer sequencer: clear, lobby, optional countdown, race, winner hold.
// Define RACE_COUNTDOWN_EN to insert a 3-2-1 countdown (screen 11) between lobby and race.
module race_game_controller #(
  parameter int unsigned N_PLAYERS     = 4,
  parameter int unsigned MAX_POS       = 16,
  parameter int unsigned FINISH_CYCLES = 50000000,
  parameter int unsigned IDLE_CYCLES   = 500000000,
  parameter int unsigned CD_CYCLES     = 25000000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start_btn,
  input  logic [N_PLAYERS-1:0]                 ready,
  input  logic [N_PLAYERS-1:0]                 activity,
  input  logic [N_PLAYERS*$clog2(MAX_POS)-1:0] pos_flat,
  output logic [1:0]                           current_screen,
  output logic                                 players_reset,
  output logic [$clog2(N_PLAYERS)-1:0]         winner_id,
  output logic                                 winner_valid,
  output logic [1:0]                           countdown
);
  localparam int unsigned PW      = $clog2(MAX_POS);
  localparam int unsigned WW      = $clog2(N_PLAYERS);
  localparam int unsigned MAX_FI  = (FINISH_CYCLES > IDLE_CYCLES) ? FINISH_CYCLES : IDLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_FI > CD_CYCLES) ? MAX_FI : CD_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC) + 1;

`ifdef RACE_COUNTDOWN_EN
  typedef enum logic [2:0] {S_CLEAR, S_LOBBY, S_COUNTDOWN, S_RACE, S_WINNER} state_t;
`else
  typedef enum logic [2:0] {S_CLEAR, S_LOBBY, S_RACE, S_WINNER} state_t;
`endif

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d, timer_inc;
  logic            start_prev_q, start_edge_q;
  logic            finish;
  logic [WW-1:0]   win_lane, win_d;
  logic [1:0]      screen_d;
  logic            prst_d, wvalid_d;
`ifdef RACE_COUNTDOWN_EN
  logic [1:0]      cd_d;
`endif

  // Lowest ready lane at or past the last track cell wins.
  always_comb begin
    finish   = 1'b0;
    win_lane = '0;
    for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
      if (ready[i] && (pos_flat[i*PW +: PW] >= PW'(MAX_POS - 1))) begin
        finish   = 1'b1;
        win_lane = WW'(i);
      end
    end
  end

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + TW'(1);

  // Next state, shared timer and registered-output decode.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_inc;
    win_d    = winner_id;
    screen_d = 2'b00;
    prst_d   = 1'b0;
    wvalid_d = 1'b0;
`ifdef RACE_COUNTDOWN_EN
    cd_d     = countdown;
`endif
    case (state_q)
      S_CLEAR: begin
        if ((timer_q >= TW'(1)) && (ready == '0) && (pos_flat == '0)) state_d = S_LOBBY;
      end
      S_LOBBY: begin
        if (start_edge_q && (ready != '0)) begin
`ifdef RACE_COUNTDOWN_EN
          state_d = S_COUNTDOWN;
          cd_d    = 2'd3;
`else
          state_d = S_RACE;
`endif
        end
      end
`ifdef RACE_COUNTDOWN_EN
      S_COUNTDOWN: begin
        if (ready == '0) begin
          state_d = S_LOBBY;
        end else if (timer_q == TW'(CD_CYCLES - 1)) begin
          if (countdown == 2'd1) begin
            state_d = S_RACE;
          end else begin
            cd_d    = countdown - 2'd1;
            timer_d = '0;
          end
        end
      end
`endif
      S_RACE: begin
        if (finish) begin
          state_d = S_WINNER;
          win_d   = win_lane;
        end else if (activity != '0) begin
          timer_d = '0;
        end else if (timer_q == TW'(IDLE_CYCLES - 1)) begin
          state_d = S_CLEAR;
        end
      end
      S_WINNER: begin
        if (timer_q == TW'(FINISH_CYCLES - 1)) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase

    if (state_d != state_q) timer_d = '0;

    case (state_d)
      S_CLEAR:     prst_d = 1'b1;
      S_RACE:      screen_d = 2'b01;
      S_WINNER: begin
        screen_d = 2'b10;
        wvalid_d = 1'b1;
      end
`ifdef RACE_COUNTDOWN_EN
      S_COUNTDOWN: screen_d = 2'b11;
`endif
      default: ;
    endcase
`ifdef RACE_COUNTDOWN_EN
    if (state_d != S_COUNTDOWN) cd_d = 2'd0;
`endif
  end

  // Start edge is registered, so a press acts one cycle after it is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_CLEAR;
      timer_q        <= '0;
      start_prev_q   <= 1'b1;
      start_edge_q   <= 1'b0;
      current_screen <= 2'b00;
      players_reset  <= 1'b1;
      winner_valid   <= 1'b0;
      winner_id      <= '0;
`ifdef RACE_COUNTDOWN_EN
      countdown      <= 2'd0;
`endif
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      start_prev_q   <= start_btn;
      start_edge_q   <= start_btn & ~start_prev_q;
      current_screen <= screen_d;
      players_reset  <= prst_d;
      winner_valid   <= wvalid_d;
      winner_id      <= win_d;
`ifdef RACE_COUNTDOWN_EN
      countdown      <= cd_d;
`endif
    end
  end

`ifndef RACE_COUNTDOWN_EN
  assign countdown = 2'd0;
`endif

endmodule

// File: tb/tb_race_game_controller.sv
// Scoreboard bench for race_game_controller: a phase-level game model predicts every cycle's outputs.
module tb_race_game_controller;
  localparam int NP = 4, MP = 16, FIN = 8, IDLE = 20, CD = 4;
  localparam int PH_CLEAR = 0, PH_LOBBY = 1, PH_CD = 2, PH_RACE = 3, PH_WIN = 4;
`ifdef RACE_COUNTDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start_btn;
  logic [3:0]  ready, activity;
  logic [3:0]  p [4];
  logic [15:0] pos_flat;
  logic [1:0]  current_screen, countdown, winner_id;
  logic        players_reset, winner_valid;

  assign pos_flat = {p[3], p[2], p[1], p[0]};
  always #5 clk = ~clk;

  race_game_controller #(
    .N_PLAYERS(NP), .MAX_POS(MP), .FINISH_CYCLES(FIN), .IDLE_CYCLES(IDLE), .CD_CYCLES(CD)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .ready(ready), .activity(activity),
    .pos_flat(pos_flat), .current_screen(current_screen), .players_reset(players_reset),
    .winner_id(winner_id), .winner_valid(winner_valid), .countdown(countdown)
  );

  // Game model: phase plus a phase-specific count of cycles.
  int m_ph = PH_CLEAR, m_cnt = 1, m_wid = 0;
  bit m_pend = 1'b0, m_last = 1'b1;
  int cyc = 0, n_checks = 0, n_pass = 0;
  logic [7:0] exp_q [$];
  bit stim_done = 1'b0;

  task automatic go(input int ph);
    m_ph  = ph;
    m_cnt = (ph == PH_CLEAR || ph == PH_WIN) ? 1 : 0;
  endtask

  task automatic model_step();
    bit edge_seen;
    int lane;
    edge_seen = m_pend;
    lane      = -1;
    m_pend    = start_btn & ~m_last;
    m_last    = start_btn;
    if (reset) begin
      go(PH_CLEAR);
      m_wid  = 0;
      m_pend = 1'b0;
      m_last = 1'b1;
      return;
    end
    case (m_ph)
      PH_CLEAR: if (m_cnt >= 2 && ready == 4'd0 && pos_flat == 16'd0) go(PH_LOBBY); else m_cnt++;
      PH_LOBBY: if (edge_seen && ready != 4'd0) go(CD_EN ? PH_CD : PH_RACE);
      PH_CD: begin
        if (ready == 4'd0) go(PH_LOBBY);
        else begin
          m_cnt++;
          if (m_cnt == 3 * CD) go(PH_RACE);
        end
      end
      PH_RACE: begin
        for (int i = NP - 1; i >= 0; i--) if (ready[i] && int'(p[i]) >= MP - 1) lane = i;
        if (lane >= 0) begin
          m_wid = lane;
          go(PH_WIN);
        end else begin
          m_cnt = (activity != 4'd0) ? 0 : m_cnt + 1;
          if (m_cnt >= IDLE) go(PH_CLEAR);
        end
      end
      PH_WIN: if (m_cnt >= FIN) go(PH_CLEAR); else m_cnt++;
      default: go(PH_CLEAR);
    endcase
  endtask

  function automatic logic [7:0] expect_vec();
    logic [1:0] scr, cdv;
    scr = (m_ph == PH_RACE) ? 2'd1 : (m_ph == PH_WIN) ? 2'd2 : (m_ph == PH_CD) ? 2'd3 : 2'd0;
    cdv = (m_ph == PH_CD) ? 2'(3 - m_cnt / CD) : 2'd0;
    return {scr, m_ph == PH_CLEAR, m_ph == PH_WIN, 2'(m_wid), cdv};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    exp_q.push_back(expect_vec());
    cyc++;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    tick();
  endtask

  task automatic wait_phase(input int ph, input int limit);
    for (int k = 0; k < limit && m_ph != ph; k++) tick();
  endtask

  task automatic zero_pos();
    for (int i = 0; i < NP; i++) p[i] = 4'd0;
  endtask

  // Monitor: every clocked output is compared against the oldest prediction.
  initial begin
    logic [7:0] e, a;
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {current_screen, players_reset, winner_valid, winner_id, countdown};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL outputs @cycle %0d: got scr=%b prst=%b wv=%b wid=%0d cd=%0d, want scr=%b prst=%b wv=%b wid=%0d cd=%0d",
                      cyc, a[7:6], a[5], a[4], a[3:2], a[1:0], e[7:6], e[5], e[4], e[3:2], e[1:0]);
      end
    end
  end

  initial begin
    int idle_burst;
    idle_burst = 0;
    reset = 1'b1; start_btn = 1'b0; ready = 4'b0001; activity = 4'd0;
    zero_pos();
    p[0] = 4'd5;
    repeat (3) tick();
    reset = 1'b0;
    repeat (6) tick();
    ready = 4'd0; p[0] = 4'd0;
    repeat (3) tick();
    pulse_start();
    repeat (4) tick();
    ready = 4'b0101;
    pulse_start();
    wait_phase(PH_RACE, 30);
    repeat (2) tick();
    // Two lanes finish together.
    ready = 4'b1111; activity = 4'b1010; p[1] = 4'd14; p[3] = 4'd14;
    tick();
    p[1] = 4'd15; p[3] = 4'd15;
    tick();
    activity = 4'd0;
    repeat (10) tick();
    ready = 4'd0; zero_pos();
    wait_phase(PH_LOBBY, 10);
    // Non-ready lane at the finish, then idle abort.
    ready = 4'b1011;
    pulse_start();
    wait_phase(PH_RACE, 30);
    p[2] = 4'd15; activity = 4'b0100;
    tick();
    activity = 4'd0;
    repeat (25) tick();
    ready = 4'd0; zero_pos();
    wait_phase(PH_LOBBY, 10);
    // Reset during the winner screen.
    ready = 4'b0001;
    pulse_start();
    wait_phase(PH_RACE, 30);
    p[0] = 4'd15;
    wait_phase(PH_WIN, 5);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; ready = 4'd0; zero_pos();
    wait_phase(PH_LOBBY, 10);
    // Start held from the winner screen into the lobby.
    ready = 4'b0001;
    pulse_start();
    wait_phase(PH_RACE, 30);
    p[0] = 4'd15;
    wait_phase(PH_WIN, 5);
    start_btn = 1'b1; ready = 4'd0; zero_pos();
    wait_phase(PH_LOBBY, 30);
    ready = 4'b0011;
    repeat (5) tick();
    start_btn = 1'b0;
    tick();
    start_btn = 1'b1;
    tick();
    wait_phase(PH_RACE, 30);
    start_btn = 1'b0;

    // Randomised play driven by the model's own phase.
    for (int c = 0; c < 3000; c++) begin
      case (m_ph)
        PH_CLEAR: begin
          activity = 4'd0;
          if ($urandom_range(0, 2) == 0) begin
            ready = 4'($urandom);
            p[$urandom_range(0, 3)] = 4'($urandom_range(0, 3));
          end else begin
            ready = 4'd0;
            zero_pos();
          end
          if ($urandom_range(0, 5) == 0) start_btn = ~start_btn;
        end
        PH_LOBBY: begin
          ready    = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
          activity = 4'($urandom);
          if ($urandom_range(0, 2) == 0) start_btn = ~start_btn;
        end
        PH_CD: begin
          if ($urandom_range(0, 19) == 0) ready = 4'd0;
          activity = 4'($urandom);
        end
        PH_RACE: begin
          activity = 4'd0;
          if (idle_burst > 0) idle_burst--;
          else if ($urandom_range(0, 39) == 0) idle_burst = $urandom_range(15, 25);
          else begin
            for (int i = 0; i < NP; i++) begin
              if ($urandom_range(0, 2) == 0 && p[i] < 4'd15) begin
                p[i]        = p[i] + 4'd1;
                activity[i] = 1'b1;
              end
            end
          end
          if ($urandom_range(0, 49) == 0) p[$urandom_range(0, 3)] = 4'd15;
          if ($urandom_range(0, 29) == 0) ready = 4'($urandom);
          if ($urandom_range(0, 3) == 0) start_btn = ~start_btn;
        end
        default: begin
          if ($urandom_range(0, 1) == 0) start_btn = ~start_btn;
          activity = 4'($urandom);
        end
      endcase
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    repeat (2) tick();
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    #20;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d leftover, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no end of stimulus, want completion");
    $fatal(1, "bench timeout");
  end
endmodule
